// File: rtl/tmr0_prescaler.sv
// Timer0 with shared 8-bit prescaler, synchronized T0CKI edge source and TMR0 write inhibit.
// Optional watchdog path enabled by defining WDT_EN.
module tmr0_prescaler #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WDT_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] OPTION,
  input  logic       T0CKI,
  input  logic       TMR0_wr,
  input  logic [7:0] W,
  input  logic       CLRWDT,
  output logic [7:0] TMR0,
  output logic       T0IF,
  output logic       WDT_TO
);

  localparam int unsigned PSC_W = 8;
  localparam int unsigned INH_W = 2;

  logic                   w_t0cs;
  logic                   w_t0se;
  logic                   w_psa;
  logic [2:0]             w_ps;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_lvl_q;
  logic                   r_ev_ext;
  logic                   r_psa_q;
  logic [PSC_W-1:0]       r_psc;
  logic [PSC_W-1:0]       w_psc_nxt;
  logic [7:0]             r_tmr0;
  logic                   r_t0if;
  logic [INH_W-1:0]       r_inh;

  logic                   w_sync_out;
  logic [PSC_W-1:0]       w_mask;
  logic                   w_hit;
  logic                   w_ev;
  logic                   w_psa_chg;
  logic                   w_inc;

  assign w_t0cs = OPTION[5];
  assign w_t0se = OPTION[4];
  assign w_psa  = OPTION[3];
  assign w_ps   = OPTION[2:0];

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_mask     = PSC_W'((9'd2 << w_ps) - 9'd1);
  assign w_hit      = ((r_psc & w_mask) == w_mask);
  assign w_ev       = w_t0cs ? r_ev_ext : 1'b1;
  assign w_psa_chg  = w_psa ^ r_psa_q;
  assign w_inc      = w_ev & ~w_psa_chg & (r_inh == INH_W'(0)) & (w_psa | w_hit);

  // External pin synchronizer followed by a registered edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync   <= '0;
      r_lvl_q  <= 1'b0;
      r_ev_ext <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], T0CKI};
      r_lvl_q  <= w_sync_out;
      r_ev_ext <= w_t0se ? (r_lvl_q & ~w_sync_out) : (~r_lvl_q & w_sync_out);
    end
  end

  // Prescaler next value: PSA change beats write-clear beats advance
  always_comb begin
    w_psc_nxt = r_psc;
    if (w_psa_chg) begin
      w_psc_nxt = '0;
    end else if (!w_psa) begin
      if (TMR0_wr)   w_psc_nxt = '0;
      else if (w_ev) w_psc_nxt = r_psc + PSC_W'(1);
    end else begin
`ifdef WDT_EN
      if (CLRWDT) w_psc_nxt = '0;
      else        w_psc_nxt = r_psc + PSC_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psa_q <= 1'b0;
      r_psc   <= '0;
      r_tmr0  <= '0;
      r_t0if  <= 1'b0;
      r_inh   <= '0;
    end else begin
      r_psa_q <= w_psa;
      r_psc   <= w_psc_nxt;
      r_t0if  <= w_inc & ~TMR0_wr & (r_tmr0 == 8'hFF);
      if (TMR0_wr) begin
        r_tmr0 <= W;
        r_inh  <= INH_W'(2);
      end else begin
        if (w_inc)                r_tmr0 <= r_tmr0 + 8'd1;
        if (r_inh != INH_W'(0))   r_inh  <= r_inh - INH_W'(1);
      end
    end
  end

`ifdef WDT_EN
  logic [WDT_W-1:0] r_wdt;
  logic             r_wdt_to;
  logic             w_wdt_adv;

  // With PSA=1 the watchdog ticks once per prescaler period
  assign w_wdt_adv = w_psa ? (w_hit & ~w_psa_chg) : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdt    <= '0;
      r_wdt_to <= 1'b0;
    end else if (CLRWDT) begin
      r_wdt    <= '0;
      r_wdt_to <= 1'b0;
    end else begin
      r_wdt_to <= w_wdt_adv & (&r_wdt);
      if (w_wdt_adv) r_wdt <= r_wdt + WDT_W'(1);
    end
  end

  assign WDT_TO = r_wdt_to;
`else
  logic w_unused;
  assign w_unused = ^{CLRWDT, 32'(WDT_W)};
  assign WDT_TO   = 1'b0;
`endif

  assign TMR0 = r_tmr0;
  assign T0IF = r_t0if;

endmodule

// File: tb/tb_tmr0_prescaler.sv
// Directed self-checking bench for tmr0_prescaler.
module tb_tmr0_prescaler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] OPTION;
  logic       T0CKI;
  logic       TMR0_wr;
  logic [7:0] W;
  logic       CLRWDT;
  logic [7:0] TMR0;
  logic       T0IF;
  logic       WDT_TO;

  int n_checks = 0;
  int n_errors = 0;

  tmr0_prescaler #(.SYNC_STAGES(2), .WDT_W(4)) dut (
    .clk(clk), .rst(rst), .OPTION(OPTION), .T0CKI(T0CKI), .TMR0_wr(TMR0_wr),
    .W(W), .CLRWDT(CLRWDT), .TMR0(TMR0), .T0IF(T0IF), .WDT_TO(WDT_TO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int gap;
    bit found;
    rst = 1'b1; OPTION = 8'h00; T0CKI = 1'b0; TMR0_wr = 1'b0; W = 8'h00; CLRWDT = 1'b0;
    tick(); tick();
    chk("reset_tmr0", 32'(TMR0), 32'h00);
    chk("reset_t0if", 32'(T0IF), 32'h0);
    chk("reset_wdt_to", 32'(WDT_TO), 32'h0);
    chk("reset_psc", 32'(dut.r_psc), 32'h00);
    rst = 1'b0;

    // Internal clock, 1:2 prescale, overflow at cycle 512
    pulses = 0;
    for (int i = 1; i <= 512; i++) begin
      tick();
      if (T0IF) pulses++;
      if (i == 2)   chk("div2_first", 32'(TMR0), 32'h01);
      if (i == 510) chk("div2_ff", 32'(TMR0), 32'hFF);
      if (i == 511) chk("div2_hold", 32'(TMR0), 32'hFF);
      if (i == 512) begin
        chk("div2_wrap", 32'(TMR0), 32'h00);
        chk("div2_t0if", 32'(T0IF), 32'h1);
      end
    end
    chk("div2_pulses", 32'(pulses), 32'd1);
    tick();
    chk("t0if_one_cycle", 32'(T0IF), 32'h0);
    tick();
    chk("div2_after", 32'(TMR0), 32'h01);
    #2 rst = 1'b1;
    #1 chk("async_rst_tmr0", 32'(TMR0), 32'h00);
    tick();
    OPTION = 8'h08;
    rst = 1'b0;
    tick(); tick(); tick();

    // PSA=1 write inhibit then overflow
    TMR0_wr = 1'b1; W = 8'hFE;
    tick();
    TMR0_wr = 1'b0;
    chk("wr_load", 32'(TMR0), 32'hFE);
    tick(); chk("wr_inh1", 32'(TMR0), 32'hFE);
    tick(); chk("wr_inh2", 32'(TMR0), 32'hFE);
    tick(); chk("wr_step_ff", 32'(TMR0), 32'hFF);
    tick();
    chk("wr_wrap", 32'(TMR0), 32'h00);
    chk("wr_t0if", 32'(T0IF), 32'h1);
    tick();
    chk("wr_t0if_clr", 32'(T0IF), 32'h0);
    chk("wr_next", 32'(TMR0), 32'h01);

    // Write collides with due overflow increment
    TMR0_wr = 1'b1; W = 8'hFF;
    tick();
    TMR0_wr = 1'b0;
    tick(); tick();
    chk("coll_pre", 32'(TMR0), 32'hFF);
    TMR0_wr = 1'b1; W = 8'h10;
    tick();
    TMR0_wr = 1'b0;
    chk("coll_tmr0", 32'(TMR0), 32'h10);
    chk("coll_t0if", 32'(T0IF), 32'h0);
    tick();
    chk("coll_t0if2", 32'(T0IF), 32'h0);

    // PSA toggles clear prescaler, no increment in change cycle
    OPTION = 8'h07; TMR0_wr = 1'b1; W = 8'h40;
    tick();
    TMR0_wr = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("psa_psc5", 32'(dut.r_psc), 32'h05);
    chk("psa_tmr0_a", 32'(TMR0), 32'h40);
    OPTION = 8'h0F;
    tick();
    chk("psa_01_psc", 32'(dut.r_psc), 32'h00);
    chk("psa_01_tmr0", 32'(TMR0), 32'h40);
    tick();
    chk("psa_1_inc", 32'(TMR0), 32'h41);
    OPTION = 8'h07;
    tick();
    chk("psa_10_psc", 32'(dut.r_psc), 32'h00);
    chk("psa_10_tmr0", 32'(TMR0), 32'h41);

    // External rising edges, PS=0
    OPTION = 8'h20; TMR0_wr = 1'b1; W = 8'h00;
    tick();
    TMR0_wr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int r = 0; r < 4; r++) begin
      T0CKI = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        tick();
        if (r == 1 && k == 3) chk("ext_rise_lat_hold", 32'(TMR0), 32'h00);
        if (r == 1 && k == 4) chk("ext_rise_lat_inc", 32'(TMR0), 32'h01);
      end
      T0CKI = 1'b0;
      for (int k = 0; k < 4; k++) tick();
    end
    for (int i = 0; i < 6; i++) tick();
    chk("ext_rise_total", 32'(TMR0), 32'h02);

    // External falling edges
    OPTION = 8'h30; TMR0_wr = 1'b1; W = 8'h00;
    tick();
    TMR0_wr = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int r = 0; r < 4; r++) begin
      T0CKI = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      if (r == 1) chk("ext_fall_mid", 32'(TMR0), 32'h00);
      T0CKI = 1'b0;
      for (int k = 0; k < 4; k++) tick();
    end
    for (int i = 0; i < 6; i++) tick();
    chk("ext_fall_total", 32'(TMR0), 32'h02);

    // Watchdog
    OPTION = 8'h08;
    tick();
`ifdef WDT_EN
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (WDT_TO) found = 1'b1;
    end
    chk("wdt_first_seen", 32'(found), 32'h1);
    gap = 0; found = 1'b0;
    for (int i = 1; i <= 100 && !found; i++) begin
      tick();
      if (WDT_TO) begin found = 1'b1; gap = i; end
    end
    chk("wdt_period", 32'(gap), 32'd32);
    for (int i = 0; i < 19; i++) tick();
    CLRWDT = 1'b1;
    tick();
    CLRWDT = 1'b0;
    gap = 0; found = 1'b0;
    for (int i = 1; i <= 100 && !found; i++) begin
      tick();
      if (WDT_TO) begin found = 1'b1; gap = i; end
    end
    chk("wdt_after_clr", 32'(gap), 32'd32);
`else
    pulses = 0;
    CLRWDT = 1'b1;
    tick();
    CLRWDT = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (WDT_TO) pulses++;
    end
    chk("wdt_off_pulses", 32'(pulses), 32'd0);
    found = 1'b0;
    gap = 0;
    chk("wdt_off_unused", 32'(found) + 32'(gap), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tmr0_prescaler.md
Name: tmr0_prescaler

Overview:
- Timer0 with shared 8-bit prescaler. Sits directly downstream of the misc-register stage and consumes its OPTION byte (T0CS, T0SE, PSA, PS[2:0]).
- Counts internal clock cycles or synchronized T0CKI edges, and supports CPU writes to TMR0 from W.
- Reports overflow to the interrupt/status logic.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the T0CKI synchronizer (minimum 2).
- WDT_W, 10, watchdog counter width (used only with WDT_EN).

Ports:
- clk  in  1  system clock; one instruction cycle per clk.
- rst  in  1  reset.
- OPTION  in  8  [5]=T0CS, [4]=T0SE, [3]=PSA, [2:0]=PS.
- T0CKI  in  1  external timer pin, asynchronous.
- TMR0_wr  in  1  CPU write strobe for TMR0.
- W  in  8  write data.
- CLRWDT  in  1  clear watchdog and prescaler (when PSA=1).
- TMR0  out  8  timer value.
- T0IF  out  1  one-cycle overflow pulse.
- WDT_TO  out  1  one-cycle watchdog timeout pulse (0 without WDT_EN).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, rst).
  - rst=1 clears immediately: TMR0=0x00, T0IF=0, WDT_TO=0, prescaler=0, synchronizer=0, edge register=0, inhibit counter=0, WDT=0.
  - Reset mid-count discards all partial state.
- Source event (ev), evaluated each clk:
  - T0CS=0: ev=1 every cycle.
  - T0CS=1: T0CKI passes through SYNC_STAGES flops, then a registered edge detect. T0SE=0 selects rising edge, T0SE=1 selects falling edge.
  - External edge-to-ev latency: SYNC_STAGES+1 cycles.
- Prescaler: 8-bit up-counter, wraps 0xFF->0x00.
  - PSA=0 (assigned to TMR0):
    - The prescaler increments on each ev.
    - inc = ev AND prescaler[PS:0] all ones, so TMR0 advances once per 2^(PS+1) events.
    - PS=7 gives divide-by-256.
  - PSA=1: TMR0 inc = ev, and the prescaler feeds the WDT path.
  - PSA change: a registered copy of PSA is compared each cycle. On a change, the prescaler clears that cycle and produces no inc.
  - PS change: the prescaler is not cleared. The new ratio applies from the next ev.
- TMR0 write:
  - TMR0_wr=1 loads W at the edge.
  - Clears the prescaler if PSA=0.
  - Suppresses inc for the next 2 clk cycles via a 2-bit inhibit counter. Events in those cycles still advance the prescaler.
  - Write and inc in the same cycle: write wins, no T0IF.
- Overflow: inc with TMR0=0xFF gives TMR0=0x00 and T0IF=1 for exactly one cycle (registered, same edge).
- No other outputs change during inhibit except the prescaler.

Optional Feature:
- Macro: WDT_EN.
- Defined:
  - WDT_W-bit counter advances once per clk when PSA=0.
  - When PSA=1 it advances once per prescaler wrap at ratio 2^(PS+1), clocked by every clk.
  - Terminal count (all ones) followed by an advance gives WDT_TO=1 for one cycle; the counter wraps to 0.
  - CLRWDT=1: WDT=0 and, if PSA=1, prescaler=0. This takes precedence over an advance in the same cycle.
- Undefined:
  - No WDT logic. WDT_TO is tied 0 and CLRWDT is ignored.
  - Prescaler is idle while PSA=1.

Test Plan:
- Reset, then rst=0 with OPTION=0x00 (internal, PSA=0, 1:2) for 512 clk -> TMR0 steps every 2 cycles. TMR0=0xFF->0x00 at cycle 512 with a single T0IF pulse. Assert rst mid-run -> TMR0=0x00 immediately, without waiting for a clk edge.
- OPTION=0x08 (PSA=1, 1:1), write W=0xFE -> TMR0=0xFE, no change for 2 cycles, then 0xFF, then 0x00 with T0IF=1.
- OPTION=0x20 (external, rising, PSA=0, PS=0), toggle T0CKI with period 8 clk ×4 rising edges -> TMR0 +2. First increment SYNC_STAGES+1 cycles after the second rising edge. With OPTION=0x30, only falling edges count.
- TMR0=0xFF, TMR0_wr with W=0x10 on the cycle an overflow inc is due -> TMR0=0x10, T0IF stays 0.
- Toggle PSA 0->1->0 with prescaler at 0x05 -> prescaler reads 0 after each change. No spurious TMR0 increment in the change cycle.
- WDT_EN, WDT_W=4, OPTION=0x08 (PSA=1, PS=0) -> WDT_TO pulses every 32 clk. CLRWDT at clk 20 -> next WDT_TO at clk 52.
